iomem: RTL
==========

# iomem

Memory-mapped I/O responder on the processor's data-memory bus, the input/output counterpart to the display path. It decodes a small register window and holds the 32-bit word driven to the 7-segment display driver. It also debounces `btn0` and exposes its level, a sticky press flag and a press counter to software. It sits beside `dmem` on the same `we`/`a`/`wd`/`rd` signals and clocks with the processor clock.

## Interface
- `BASE`, 32'hFFFF_0000, byte address of register window (16-byte aligned)
- `DISP_RESET`, 32'h0000_0000, reset value of display register
- `DEBOUNCE_MS`, 10, consecutive `ce1ms` ticks of a changed input required to accept a new button level (1..255)
- `clk`  in  1  processor clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately
- `ce1ms`  in  1  one-`clk`-wide 1 ms enable
- `btn0`  in  1  raw asynchronous button
- `we`  in  1  write strobe, same timing as `dmem`
- `a`  in  32  byte address
- `wd`  in  32  write data
- `rd`  out  32  read data, combinational
- `hit`  out  1  combinational: `a` falls in window
- `word`  out  32  display word to display driver, registered

## Operation
- Window: `hit` = (`a[31:4]` == `BASE[31:4]`); `a[1:0]` ignored; writes act only when `we`=1 and `hit`=1.
- Offset 0x0 DISP (RW): write loads `word` <= `wd`; read returns `word`.
- Offset 0x4 STATUS: bit0 debounced level (RO), bit1 PRESS sticky flag; write with `wd[1]`=1 clears PRESS, other bits ignored; bits 31:2 read 0.
- Offset 0x8 COUNT (RO): bits 15:0 count accepted presses, wrap 16'hFFFF -> 0; bits 31:16 read 0; writes ignored.
- Offset 0xC: reads 0, writes ignored. `rd` = 0 when `hit`=0.
- Input path: two-flop synchronizer on `btn0` -> `sync`.
- Debounce FSM, states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO, 8-bit `cnt`:
  - STABLE_LO: `sync`=1 -> WAIT_HI, `cnt`=0.
  - WAIT_HI: `sync`=0 -> STABLE_LO. Else each `ce1ms` increments `cnt`. The tick making `cnt`==`DEBOUNCE_MS` -> STABLE_HI, level=1, PRESS=1, COUNT+1.
  - STABLE_HI / WAIT_LO: mirror image, release sets level=0 only, no PRESS or COUNT change.
- PRESS set and W1C clear in same cycle: set wins.
- Reset: `word`=`DISP_RESET`, level=0, PRESS=0, COUNT=0, state STABLE_LO, `cnt`=0, synchronizer flops=0.

## Timing
- DISP write: `word` updates on the `clk` edge with `we`=1; read-after-write in the next cycle returns the new value.
- `rd` and `hit` are purely combinational from `a` and current state, with zero-cycle read latency as in `dmem`.
- Button acceptance: 2 `clk` synchronizer delay, then the accepting edge is the `DEBOUNCE_MS`-th `ce1ms` pulse seen while in WAIT_*. Level, PRESS and COUNT change on that same edge.
- A glitch shorter than `DEBOUNCE_MS` ticks produces no change in level, PRESS or COUNT.
- Reset asserted mid-debounce aborts the debounce with no partial count kept. Reset asserted mid-write discards the write.

## Configuration
- `IOMEM_BTN_COUNT_EN` defined: COUNT register and counter present as above.
- Not defined: no counter logic. Offset 0x8 reads 0, and STATUS, DISP and debounce are unchanged.

## Test plan
- Reset with `DISP_RESET`=32'h1234_5678 -> `word`=32'h1234_5678, STATUS=0, COUNT=0. Release reset, write DISP 32'hDEAD_BEEF -> `word`=32'hDEAD_BEEF next cycle, read 0x0 returns it.
- `DEBOUNCE_MS`=3, hold `btn0`=1 over 5 `ce1ms` ticks -> level=1 and PRESS=1 exactly on 3rd tick edge, COUNT=1. Release for 3 ticks -> level=0, COUNT stays 1.
- Bounce: `btn0` high for 2 ticks, low, high for 2 ticks -> STATUS=0, COUNT=0 throughout.
- Write STATUS `wd`=32'h2 on the accepting edge of a press -> PRESS reads 1. A second write of 32'h2 -> PRESS reads 0.
- With `IOMEM_BTN_COUNT_EN`, preload 65535 presses (force) plus 1 press -> COUNT=0. Without the macro, read 0x8 after presses -> 0.
- Write `a`=`BASE`+0x10 with `we`=1 -> `hit`=0, `word` unchanged, `rd`=0. Assert reset during WAIT_HI -> state STABLE_LO, COUNT=0 asynchronously.

Source files
------------

// File: rtl/iomem.sv
// iomem: memory-mapped display register plus debounced button status/count window.
// Optional macro IOMEM_BTN_COUNT_EN adds the press counter (COUNT at offset 0x8).
module iomem #(
  parameter logic [31:0] BASE        = 32'hFFFF_0000,
  parameter logic [31:0] DISP_RESET  = 32'h0000_0000,
  parameter int unsigned DEBOUNCE_MS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce1ms,
  input  logic        btn0,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic [31:0] word
);
  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;
  localparam logic [7:0] DB = 8'(DEBOUNCE_MS);
  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        meta_q, sync_q, level_q, press_q;
  logic [31:0] word_q;
  logic [7:0]  cnt_inc;
  logic        wr_disp, wr_stat, accept_hi, accept_lo;
  logic [31:0] count_word;
  logic        unused_addr;
  assign hit         = a[31:4] == BASE[31:4];
  assign wr_disp     = we && hit && a[3:2] == 2'd0;
  assign wr_stat     = we && hit && a[3:2] == 2'd1;
  assign cnt_inc     = cnt_q + 8'd1;
  assign accept_hi   = state_q == WAIT_HI && sync_q && ce1ms && cnt_inc == DB;
  assign accept_lo   = state_q == WAIT_LO && !sync_q && ce1ms && cnt_inc == DB;
  assign word        = word_q;
  assign unused_addr = &{1'b0, a[1:0], accept_lo};
`ifdef IOMEM_BTN_COUNT_EN
  logic [15:0] count_q;
  assign count_word = {16'h0, count_q};
  // Press counter, advanced only on an accepted rising level.
  always_ff @(posedge clk or negedge reset)
    if (!reset) count_q <= 16'h0;
    else if (accept_hi) count_q <= count_q + 16'd1;
`else
  assign count_word = 32'h0;
`endif
  // Display register, loaded by a DISP write.
  always_ff @(posedge clk or negedge reset)
    if (!reset) word_q <= DISP_RESET;
    else if (wr_disp) word_q <= wd;
  // Two-flop synchronizer for the raw button.
  always_ff @(posedge clk or negedge reset)
    if (!reset) {sync_q, meta_q} <= 2'b00;
    else {sync_q, meta_q} <= {meta_q, btn0};
  // Debounce FSM with registered level and sticky PRESS; a press set beats a W1C clear.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= 8'd0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      unique case (state_q)
        STABLE_LO: if (sync_q) begin
          state_q <= WAIT_HI;
          cnt_q   <= 8'd0;
        end
        WAIT_HI: if (!sync_q) state_q <= STABLE_LO;
          else if (ce1ms) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == DB) begin
              state_q <= STABLE_HI;
              level_q <= 1'b1;
            end
          end
        STABLE_HI: if (!sync_q) begin
          state_q <= WAIT_LO;
          cnt_q   <= 8'd0;
        end
        WAIT_LO: if (sync_q) state_q <= STABLE_HI;
          else if (ce1ms) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == DB) begin
              state_q <= STABLE_LO;
              level_q <= 1'b0;
            end
          end
      endcase
      press_q <= accept_hi ? 1'b1 : (wr_stat && wd[1]) ? 1'b0 : press_q;
    end
  // Zero-latency read mux over the window; outside the window reads 0.
  always_comb
    rd = !hit           ? 32'h0 :
         a[3:2] == 2'd0 ? word_q :
         a[3:2] == 2'd1 ? {30'h0, press_q, level_q} :
         a[3:2] == 2'd2 ? count_word : 32'h0;
endmodule
